sram_port_arbiter: RTL and testbench

- Arbitrates the single SRAM port (16-bit address, 32-bit data, EN/WE, 1-cycle read latency) between the CPU control sequencer and the DMA copy engine.
- Sits between CTL's memory requests (fetch, LD, ST) and DMA read/write requests, and the SRAM.
- Fixed CPU priority with a starvation guard that forces a DMA grant after a bounded wait.
- Routes read-data-valid back to whichever requester issued the read.

---
 rtl/sram_port_arbiter.sv | 149 ++++++++++++++
 tb/tb_sram_port_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_arbiter.sv
// Single-port SRAM arbiter: CPU-first grants with a starvation boost for DMA; grants same-cycle, read data valid one cycle later.
// Requesters hold req until gnt (no internal buffering); ARB_STATS_EN adds saturating stall/boost counters and stats_clr.
module sram_port_arbiter #(
    parameter int MAX_WAIT = 4,
    parameter int AW       = 16,
    parameter int DW       = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_di,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_di,
    output logic          dma_gnt,
    output logic          dma_rvalid,
    output logic [AW-1:0] sram_ADDR,
    output logic [DW-1:0] sram_DI,
    output logic          sram_EN,
    output logic          sram_WE,
`ifdef ARB_STATS_EN
    input  logic          stats_clr,
    output logic [15:0]   cpu_stall_cnt,
    output logic [15:0]   dma_stall_cnt,
    output logic [15:0]   boost_cnt,
`endif
    output logic          dma_boost
);

    typedef enum logic {
        CPU_PRI   = 1'b0,
        DMA_BOOST = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        RD_NONE = 2'd0,
        RD_CPU  = 2'd1,
        RD_DMA  = 2'd2
    } owner_t;

    localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

    state_t     state_q, state_d;
    owner_t     owner_q, owner_d;
    logic [3:0] wait_q, wait_d;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= CPU_PRI;
            owner_q <= RD_NONE;
            wait_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        cpu_gnt   = 1'b0;
        dma_gnt   = 1'b0;
        sram_EN   = 1'b0;
        sram_WE   = 1'b0;
        sram_ADDR = '0;
        sram_DI   = '0;
        owner_d   = RD_NONE;
        state_d   = state_q;
        wait_d    = wait_q;

        // Grants are masked during reset so the SRAM sees no access.
        if (reset) begin
            if (state_q == DMA_BOOST) begin
                dma_gnt = dma_req;
                cpu_gnt = cpu_req & ~dma_req;
            end else begin
                cpu_gnt = cpu_req;
                dma_gnt = dma_req & ~cpu_req;
            end
        end

        if (cpu_gnt) begin
            sram_EN   = 1'b1;
            sram_WE   = cpu_we;
            sram_ADDR = cpu_addr;
            sram_DI   = cpu_di;
            owner_d   = cpu_we ? RD_NONE : RD_CPU;
        end else if (dma_gnt) begin
            sram_EN   = 1'b1;
            sram_WE   = dma_we;
            sram_ADDR = dma_addr;
            sram_DI   = dma_di;
            owner_d   = dma_we ? RD_NONE : RD_DMA;
        end

        case (state_q)
            CPU_PRI: begin
                // Boost is entered even if the DMA withdraws in the due cycle.
                if (wait_q == WAIT_MAX) begin
                    state_d = DMA_BOOST;
                    wait_d  = 4'd0;
                end else if (dma_gnt || !dma_req) begin
                    wait_d = 4'd0;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            DMA_BOOST: begin
                wait_d = 4'd0;
                if (dma_gnt || !dma_req) begin
                    state_d = CPU_PRI;
                end
            end
            default: begin
                state_d = CPU_PRI;
                wait_d  = 4'd0;
            end
        endcase
    end

    assign cpu_rvalid = reset && (owner_q == RD_CPU);
    assign dma_rvalid = reset && (owner_q == RD_DMA);
    assign dma_boost  = reset && (state_q == DMA_BOOST);

`ifdef ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (!reset || stats_clr) begin
            cpu_stall_cnt <= 16'd0;
            dma_stall_cnt <= 16'd0;
            boost_cnt     <= 16'd0;
        end else begin
            if (cpu_req && !cpu_gnt && cpu_stall_cnt != 16'hFFFF) begin
                cpu_stall_cnt <= cpu_stall_cnt + 16'd1;
            end
            if (dma_req && !dma_gnt && dma_stall_cnt != 16'hFFFF) begin
                dma_stall_cnt <= dma_stall_cnt + 16'd1;
            end
            if (state_q == CPU_PRI && state_d == DMA_BOOST && boost_cnt != 16'hFFFF) begin
                boost_cnt <= boost_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: directed scenarios plus a random phase against a reference model and read scoreboard.
module tb_sram_port_arbiter;

    localparam int MAXW = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, dma_req, dma_we;
    logic [15:0] cpu_addr, dma_addr;
    logic [31:0] cpu_di, dma_di;
    logic        cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid;
    logic [15:0] sram_ADDR;
    logic [31:0] sram_DI;
    logic        sram_EN, sram_WE, dma_boost;
    logic [31:0] sram_DO;
`ifdef ARB_STATS_EN
    logic        stats_clr = 1'b0;
    logic [15:0] cpu_stall_cnt, dma_stall_cnt, boost_cnt;
`endif

    always #5 clk = ~clk;

    sram_port_arbiter #(.MAX_WAIT(MAXW), .AW(16), .DW(32)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_di(cpu_di),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_di(dma_di),
        .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid),
        .sram_ADDR(sram_ADDR), .sram_DI(sram_DI), .sram_EN(sram_EN), .sram_WE(sram_WE),
`ifdef ARB_STATS_EN
        .stats_clr(stats_clr), .cpu_stall_cnt(cpu_stall_cnt),
        .dma_stall_cnt(dma_stall_cnt), .boost_cnt(boost_cnt),
`endif
        .dma_boost(dma_boost)
    );

    // Behavioural SRAM with one-cycle read latency, plus an independent reference copy.
    logic [31:0] mem     [0:65535];
    logic [31:0] ref_mem [0:65535];

    always @(posedge clk) begin
        if (sram_EN) begin
            if (sram_WE) mem[sram_ADDR] <= sram_DI;
            else         sram_DO <= mem[sram_ADDR];
        end
    end

    function automatic logic [31:0] pat(input int i);
        return (i == 16) ? 32'hDEADBEEF : (32'(i) * 32'h9E3779B9) ^ 32'h5A5A0000;
    endfunction

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        bit          to_dma;
        logic [31:0] dat;
    } rd_t;

    rd_t sb[$];
    bit  mon_on = 1'b0;
    bit  m_boost;
    int  m_wait;

    // Reference model and scoreboard, evaluated mid-cycle while inputs are stable.
    always @(negedge clk) begin
        rd_t         e;
        bit          have;
        logic        e_cg, e_dg;
        logic [15:0] e_addr;
        logic [31:0] e_di;
        logic        e_we;
        if (mon_on) begin
            have = 1'b0;
            if (sb.size() > 0) begin
                e    = sb.pop_front();
                have = 1'b1;
            end
            if (!reset) begin
                chk("rst_cpu_gnt", 32'(cpu_gnt), 0);
                chk("rst_dma_gnt", 32'(dma_gnt), 0);
                chk("rst_en", 32'(sram_EN), 0);
                chk("rst_we", 32'(sram_WE), 0);
                chk("rst_addr", 32'(sram_ADDR), 0);
                chk("rst_cpu_rvalid", 32'(cpu_rvalid), 0);
                chk("rst_dma_rvalid", 32'(dma_rvalid), 0);
                chk("rst_boost", 32'(dma_boost), 0);
                m_boost = 1'b0;
                m_wait  = 0;
                sb.delete();
            end else begin
                e_cg = cpu_req && (!m_boost || !dma_req);
                e_dg = dma_req && (m_boost || !cpu_req);
                e_addr = e_cg ? cpu_addr : (e_dg ? dma_addr : 16'h0);
                e_di   = e_cg ? cpu_di   : (e_dg ? dma_di   : 32'h0);
                e_we   = e_cg ? cpu_we   : (e_dg ? dma_we   : 1'b0);
                chk("m_cpu_gnt", 32'(cpu_gnt), 32'(e_cg));
                chk("m_dma_gnt", 32'(dma_gnt), 32'(e_dg));
                chk("m_boost", 32'(dma_boost), 32'(m_boost));
                chk("m_en", 32'(sram_EN), 32'(e_cg | e_dg));
                chk("m_we", 32'(sram_WE), 32'(e_we));
                chk("m_addr", 32'(sram_ADDR), 32'(e_addr));
                chk("m_di", sram_DI, e_di);
                chk("sb_cpu_rvalid", 32'(cpu_rvalid), 32'(have && !e.to_dma));
                chk("sb_dma_rvalid", 32'(dma_rvalid), 32'(have && e.to_dma));
                if (have) chk("sb_rdata", sram_DO, e.dat);
                if (e_cg || e_dg) begin
                    if (e_we) ref_mem[e_addr] = e_di;
                    else      sb.push_back('{to_dma: e_dg, dat: ref_mem[e_addr]});
                end
                if (!m_boost) begin
                    if (m_wait == MAXW) begin
                        m_boost = 1'b1;
                        m_wait  = 0;
                    end else if (dma_req && !e_dg) begin
                        m_wait = m_wait + 1;
                    end else begin
                        m_wait = 0;
                    end
                end else begin
                    m_boost = 1'b0;
                    m_wait  = 0;
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic drive(input logic cr, input logic cw, input logic [15:0] ca, input logic [31:0] cd,
                         input logic dr, input logic dw, input logic [15:0] da, input logic [31:0] dd);
        cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_di = cd;
        dma_req = dr; dma_we = dw; dma_addr = da; dma_di = dd;
    endtask

    task automatic idle();
        drive(0, 0, 16'h0, 32'h0, 0, 0, 16'h0, 32'h0);
    endtask

    logic prev_cg, prev_dg;

    initial begin
        for (int i = 0; i < 65536; i++) begin
            mem[i]     = pat(i);
            ref_mem[i] = pat(i);
        end
        reset = 1'b0;
        idle();

        // Requests during reset must not reach the SRAM.
        cyc(); mon_on = 1'b1; cpu_req = 1'b1;
        settle();
        chk("reset_cpu_gnt", 32'(cpu_gnt), 0);
        chk("reset_sram_en", 32'(sram_EN), 0);
        cyc(); reset = 1'b1; idle(); settle();

        // CPU-only read.
        cyc(); drive(1, 0, 16'h0010, 0, 0, 0, 0, 0); settle();
        chk("cpu_rd_gnt", 32'(cpu_gnt), 1);
        chk("cpu_rd_en", 32'(sram_EN), 1);
        chk("cpu_rd_addr", 32'(sram_ADDR), 32'h10);
        cyc(); idle(); settle();
        chk("cpu_rd_rvalid", 32'(cpu_rvalid), 1);
        chk("cpu_rd_data", sram_DO, 32'hDEADBEEF);
        chk("cpu_rd_dma_rvalid", 32'(dma_rvalid), 0);

        // Sustained conflict: one boosted DMA grant in cycle 5.
        for (int k = 0; k < 10; k++) begin
            cyc();
            if (k == 0) drive(1, 0, 16'h0020, 0, 1, 0, 16'h0030, 0);
            settle();
            chk($sformatf("conf_cpu_gnt_%0d", k), 32'(cpu_gnt), 32'(k != 5));
            chk($sformatf("conf_dma_gnt_%0d", k), 32'(dma_gnt), 32'(k == 5));
            chk($sformatf("conf_boost_%0d", k), 32'(dma_boost), 32'(k == 5));
        end
        cyc(); idle(); settle();

        // DMA write while CPU idle, then CPU reads it back.
        cyc(); drive(0, 0, 0, 0, 1, 1, 16'h0100, 32'h12345678); settle();
        chk("dma_wr_gnt", 32'(dma_gnt), 1);
        chk("dma_wr_we", 32'(sram_WE), 1);
        chk("dma_wr_di", sram_DI, 32'h12345678);
        cyc(); drive(1, 0, 16'h0100, 0, 0, 0, 0, 0); settle();
        chk("dma_wr_no_rvalid", 32'(dma_rvalid), 0);
        cyc(); idle(); settle();
        chk("wr_rb_rvalid", 32'(cpu_rvalid), 1);
        chk("wr_rb_data", sram_DO, 32'h12345678);

        // Alternating-owner reads.
        cyc(); drive(1, 0, 16'h0001, 0, 0, 0, 0, 0); settle();
        cyc(); drive(0, 0, 0, 0, 1, 0, 16'h0002, 0); settle();
        chk("alt_cpu_rvalid", 32'(cpu_rvalid), 1);
        chk("alt_cpu_data", sram_DO, pat(1));
        chk("alt_dma_rvalid0", 32'(dma_rvalid), 0);
        cyc(); idle(); settle();
        chk("alt_dma_rvalid", 32'(dma_rvalid), 1);
        chk("alt_dma_data", sram_DO, pat(2));
        chk("alt_cpu_rvalid1", 32'(cpu_rvalid), 0);

        // DMA withdraws in the cycle the boost is due.
        for (int k = 0; k < 4; k++) begin
            cyc();
            if (k == 0) drive(1, 0, 16'h0020, 0, 1, 0, 16'h0030, 0);
            settle();
        end
        cyc(); dma_req = 1'b0; settle();
        chk("wd_boost4", 32'(dma_boost), 0);
        cyc(); settle();
        chk("wd_boost5", 32'(dma_boost), 1);
        chk("wd_dma_gnt5", 32'(dma_gnt), 0);
        chk("wd_cpu_gnt5", 32'(cpu_gnt), 1);
        cyc(); settle();
        chk("wd_boost6", 32'(dma_boost), 0);
        cyc(); idle(); settle();

        // Reset lands right after a granted DMA read.
        cyc(); drive(0, 0, 0, 0, 1, 0, 16'h0002, 0); settle();
        chk("rr_dma_gnt", 32'(dma_gnt), 1);
        cyc(); reset = 1'b0; drive(1, 0, 16'h0005, 0, 1, 0, 16'h0006, 0); settle();
        chk("rr_dma_rvalid", 32'(dma_rvalid), 0);
        chk("rr_sram_en", 32'(sram_EN), 0);
        chk("rr_boost", 32'(dma_boost), 0);
        cyc(); reset = 1'b1; idle(); settle();
        chk("rr_rvalid_dropped", 32'(dma_rvalid), 0);

        // Partial starvation followed by reset: the wait count starts over.
        for (int k = 0; k < 3; k++) begin
            cyc();
            if (k == 0) drive(1, 0, 16'h0020, 0, 1, 0, 16'h0030, 0);
            settle();
        end
        cyc(); reset = 1'b0; settle();
        for (int k = 0; k < 7; k++) begin
            cyc();
            if (k == 0) reset = 1'b1;
            settle();
            chk($sformatf("wr_dma_gnt_%0d", k), 32'(dma_gnt), 32'(k == 5));
        end
        cyc(); idle(); settle();

        // Random traffic honouring the hold-until-granted contract.
        prev_cg = 1'b0;
        prev_dg = 1'b0;
        for (int n = 0; n < 400; n++) begin
            cyc();
            if (!(cpu_req && !prev_cg)) begin
                cpu_req  = ($urandom_range(0, 9) < 6);
                cpu_we   = $urandom_range(0, 1) == 1;
                cpu_addr = 16'($urandom_range(0, 15));
                cpu_di   = $urandom;
            end
            if (!(dma_req && !prev_dg)) begin
                dma_req  = ($urandom_range(0, 9) < 6);
                dma_we   = $urandom_range(0, 1) == 1;
                dma_addr = 16'($urandom_range(0, 15));
                dma_di   = $urandom;
            end
            reset = ($urandom_range(0, 60) != 0);
            settle();
            prev_cg = cpu_gnt;
            prev_dg = dma_gnt;
        end
        cyc(); reset = 1'b1; idle(); settle();
        cyc(); settle();
        chk("sb_drained", 32'(sb.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
